// File: rtl/tile_rom_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : tile_rom_arbiter_if
// Description : Requester-side and SDRAM-side bus of the tile-ROM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface tile_rom_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int AW      = 18,
    parameter int DW      = 32
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*AW-1:0] addr;
    logic [DW-1:0]         data;
    logic [NUM_REQ-1:0]    valid;
    logic                  sdram_req;
    logic [AW-1:0]         sdram_addr;
    logic [DW-1:0]         sdram_data;
    logic                  sdram_valid;
    logic [2:0]            grant;

    // master: the tile caches plus the SDRAM controller; slave: the arbiter
    modport master (
        output req, addr, sdram_data, sdram_valid,
        input  data, valid, sdram_req, sdram_addr, grant
    );
    modport slave (
        input  req, addr, sdram_data, sdram_valid,
        output data, valid, sdram_req, sdram_addr, grant
    );
endinterface
`default_nettype wire

// File: rtl/tile_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tile_rom_arbiter
// Description : Round-robin share of one SDRAM tile-ROM read port, one read
//               outstanding, registered data with per-requester valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_rom_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int AW      = 18,
    parameter int DW      = 32
) (
    input  logic              clk,
    input  logic              reset,
    tile_rom_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [2:0]         rr_q, rr_d;
    logic [2:0]         grant_q, grant_d;
    logic [NUM_REQ-1:0] served_q, served_d;
    logic [NUM_REQ-1:0] valid_q, valid_d;
    logic               sdram_req_q, sdram_req_d;
    logic [AW-1:0]      sdram_addr_q, sdram_addr_d;
    logic [DW-1:0]      data_q, data_d;

    logic [NUM_REQ-1:0] w_eligible;
    logic [NUM_REQ-1:0] w_gnt_onehot;
    logic               w_found;
    logic [2:0]         w_pick;
    logic [AW-1:0]      w_pick_addr;
    int                 w_idx;

    // Scan downward over rotation offsets so the lowest offset from rr wins.
    always_comb begin
        w_eligible = bus.req & ~served_q;
        w_found    = 1'b0;
        w_pick     = '0;
        w_idx      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = (int'(rr_q) + k) % NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == w_idx && w_eligible[i]) begin
                    w_found = 1'b1;
                    w_pick  = 3'(i);
                end
            end
        end
    end

    always_comb begin
        w_pick_addr  = '0;
        w_gnt_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (3'(i) == w_pick) begin
                w_pick_addr = bus.addr[i*AW +: AW];
            end
            if (3'(i) == grant_q) begin
                w_gnt_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_found) state_d = S_WAIT;
            S_WAIT:  if (bus.sdram_valid) state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The access always runs to completion; the strobe is suppressed if the
    // requester has since let go of req.
    always_comb begin
        rr_d         = rr_q;
        grant_d      = grant_q;
        sdram_req_d  = sdram_req_q;
        sdram_addr_d = sdram_addr_q;
        data_d       = data_q;
        valid_d      = '0;
        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    grant_d      = w_pick;
                    sdram_addr_d = w_pick_addr;
                    sdram_req_d  = 1'b1;
                    rr_d         = (w_pick == 3'(NUM_REQ - 1)) ? 3'd0 : w_pick + 3'd1;
                end
            end
            S_WAIT: begin
                if (bus.sdram_valid) begin
                    data_d      = bus.sdram_data;
                    sdram_req_d = 1'b0;
                    valid_d     = w_gnt_onehot & bus.req;
                end
            end
            default: sdram_req_d = 1'b0;
        endcase
        served_d = (served_q | valid_d) & bus.req;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q         <= '0;
            grant_q      <= '0;
            served_q     <= '0;
            valid_q      <= '0;
            sdram_req_q  <= 1'b0;
            sdram_addr_q <= '0;
            data_q       <= '0;
        end else begin
            rr_q         <= rr_d;
            grant_q      <= grant_d;
            served_q     <= served_d;
            valid_q      <= valid_d;
            sdram_req_q  <= sdram_req_d;
            sdram_addr_q <= sdram_addr_d;
            data_q       <= data_d;
        end
    end

    assign bus.data       = data_q;
    assign bus.valid      = valid_q;
    assign bus.sdram_req  = sdram_req_q;
    assign bus.sdram_addr = sdram_addr_q;
    assign bus.grant      = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_tile_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tile_rom_arbiter
// Description : Scoreboard bench for tile_rom_arbiter with a fixed-latency
//               SDRAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_rom_arbiter;
    localparam int NUM_REQ = 3;
    localparam int AW      = 18;
    localparam int DW      = 32;
    localparam int LAT     = 5;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } exp_t;

    logic          clk;
    logic          reset;
    logic [AW-1:0] taddr [NUM_REQ];

    exp_t sb[$];
    int   grant_log[$];
    exp_t mon_e;
    logic mon_prev_sreq;
    int   n_checks;
    int   n_fails;
    int   n_valid;
    int   stray_req_n;
    int   stray_done_n;
    int   mdl_cnt;
    bit   mdl_busy;
    int   dtim [NUM_REQ];
    int   rtim [NUM_REQ];
    int   g0;
    int   nv0;

    tile_rom_arbiter_if #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) bus ();

    tile_rom_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.addr = {taddr[2], taddr[1], taddr[0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [AW-1:0] a);
        return (a == 18'h12345) ? 32'hDEADBEEF : (32'hC0DE0000 ^ {14'd0, a});
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int idx);
        exp_t e;
        e.idx  = idx;
        e.data = rom_fn(taddr[idx]);
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        bus.req = '0;
        tick(2);
        reset   = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string tag);
        for (int c = 0; c < budget && sb.size() != 0; c++) @(negedge clk);
        check_eq(tag, 64'(sb.size()), 64'd0);
    endtask

    function automatic int log_at(input int k);
        return (grant_log.size() > k) ? grant_log[k] : -1;
    endfunction

    // SDRAM responder: fixed latency, aborts if the request is withdrawn.
    initial begin
        bus.sdram_valid = 1'b0;
        bus.sdram_data  = '0;
        stray_done_n    = 0;
        mdl_busy        = 1'b0;
        mdl_cnt         = 0;
        forever begin
            @(negedge clk);
            bus.sdram_valid = 1'b0;
            if (stray_req_n != stray_done_n) begin
                stray_done_n    = stray_req_n;
                bus.sdram_valid = 1'b1;
                bus.sdram_data  = 32'h5EA50BAD;
            end else if (mdl_busy) begin
                if (!bus.sdram_req) begin
                    mdl_busy = 1'b0;
                end else if (mdl_cnt == LAT - 1) begin
                    bus.sdram_valid = 1'b1;
                    bus.sdram_data  = rom_fn(bus.sdram_addr);
                    mdl_busy        = 1'b0;
                end else begin
                    mdl_cnt++;
                end
            end else if (bus.sdram_req) begin
                mdl_busy = 1'b1;
                mdl_cnt  = 1;
            end
        end
    end

    // Monitor: logs grants, checks latched address, pops scoreboard on valid.
    initial begin
        mon_prev_sreq = 1'b0;
        n_valid       = 0;
        forever begin
            @(negedge clk);
            if (!reset && bus.sdram_req && !mon_prev_sreq) begin
                grant_log.push_back(int'(bus.grant));
                if (int'(bus.grant) < NUM_REQ)
                    check_eq("sdram_addr", 64'(bus.sdram_addr), 64'(taddr[int'(bus.grant)]));
                else
                    check_eq("grant_range", 64'(bus.grant), 64'd0);
            end
            mon_prev_sreq = bus.sdram_req;
            if (bus.valid != '0) begin
                n_valid++;
                check_eq("valid_onehot", 64'($countones(bus.valid)), 64'd1);
                if (sb.size() == 0) begin
                    check_eq("unexpected_valid", 64'(bus.valid), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("valid_idx", 64'(bus.valid), 64'(1) << mon_e.idx);
                    check_eq("data", 64'(bus.data), 64'(mon_e.data));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_fails     = 0;
        stray_req_n = 0;
        reset       = 1'b1;
        bus.req     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            taddr[i] = '0;
            dtim[i]  = 0;
            rtim[i]  = 0;
        end
        tick(3);
        reset = 1'b0;
        check_eq("rst_sdram_req", 64'(bus.sdram_req), 64'd0);
        check_eq("rst_sdram_addr", 64'(bus.sdram_addr), 64'd0);
        check_eq("rst_data", 64'(bus.data), 64'd0);
        check_eq("rst_valid", 64'(bus.valid), 64'd0);
        check_eq("rst_grant", 64'(bus.grant), 64'd0);

        // Single request
        taddr[0] = 18'h12345;
        push_exp(0);
        bus.req = 3'b001;
        tick(1);
        check_eq("t1_latency", 64'(bus.sdram_req), 64'd1);
        check_eq("t1_grant", 64'(bus.grant), 64'd0);
        wait_drain(30, "t1_drain");
        tick(1);
        check_eq("t1_valid_width", 64'(bus.valid), 64'd0);
        check_eq("t1_data_hold", 64'(bus.data), 64'hDEADBEEF);
        bus.req = '0;
        tick(2);

        // Round-robin with drop/re-raise
        do_reset();
        taddr[0] = 18'h00100;
        taddr[1] = 18'h00200;
        taddr[2] = 18'h00300;
        for (int k = 0; k < 6; k++) push_exp(k % 3);
        g0 = grant_log.size();
        bus.req = 3'b111;
        for (int c = 0; c < 300 && sb.size() != 0; c++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.valid[i]) begin
                    dtim[i] = 2;
                end else if (dtim[i] > 0) begin
                    dtim[i]--;
                    if (dtim[i] == 0) begin
                        bus.req[i] = 1'b0;
                        rtim[i]    = 3;
                    end
                end else if (rtim[i] > 0) begin
                    rtim[i]--;
                    if (rtim[i] == 0) bus.req[i] = 1'b1;
                end
            end
        end
        bus.req = '0;
        tick(20);
        check_eq("t2_drain", 64'(sb.size()), 64'd0);
        for (int k = 0; k < 6; k++)
            check_eq($sformatf("t2_order%0d", k), 64'(log_at(g0 + k)), 64'(k % 3));

        // Hold request after being served
        do_reset();
        taddr[0] = 18'h2AAAA;
        push_exp(0);
        g0  = grant_log.size();
        nv0 = n_valid;
        bus.req = 3'b001;
        tick(LAT + 25);
        check_eq("t3_grants", 64'(grant_log.size() - g0), 64'd1);
        check_eq("t3_valids", 64'(n_valid - nv0), 64'd1);
        bus.req = '0;
        tick(2);

        // Abandon during WAIT
        do_reset();
        taddr[1] = 18'h11111;
        taddr[2] = 18'h22222;
        push_exp(2);
        g0 = grant_log.size();
        bus.req = 3'b110;
        tick(1);
        check_eq("t4_grant1", 64'(bus.grant), 64'd1);
        tick(1);
        bus.req[1] = 1'b0;
        tick(2);
        check_eq("t4_hold_req", 64'(bus.sdram_req), 64'd1);
        check_eq("t4_hold_addr", 64'(bus.sdram_addr), 64'h11111);
        wait_drain(40, "t4_drain");
        check_eq("t4_first", 64'(log_at(g0)), 64'd1);
        check_eq("t4_second", 64'(log_at(g0 + 1)), 64'd2);
        bus.req = '0;
        tick(3);

        // Reset in the middle of WAIT, then a stray completion
        do_reset();
        taddr[0] = 18'h00ABC;
        taddr[2] = 18'h3FFFF;
        bus.req = 3'b001;
        tick(3);
        reset   = 1'b1;
        bus.req = '0;
        tick(1);
        reset = 1'b0;
        check_eq("t5_sdram_req", 64'(bus.sdram_req), 64'd0);
        check_eq("t5_valid", 64'(bus.valid), 64'd0);
        check_eq("t5_grant", 64'(bus.grant), 64'd0);
        stray_req_n++;
        tick(3);
        check_eq("t5_stray_req", 64'(bus.sdram_req), 64'd0);
        check_eq("t5_stray_data", 64'(bus.data), 64'd0);
        push_exp(0);
        push_exp(2);
        g0 = grant_log.size();
        bus.req = 3'b101;
        tick(1);
        check_eq("t5_first_grant", 64'(bus.grant), 64'd0);
        wait_drain(40, "t5_drain");
        check_eq("t5_second", 64'(log_at(g0 + 1)), 64'd2);
        bus.req = '0;
        tick(3);

        // Wrap-around from rr=2
        do_reset();
        taddr[0] = 18'h01000;
        taddr[1] = 18'h01001;
        push_exp(1);
        bus.req = 3'b010;
        wait_drain(30, "t6_prep_drain");
        bus.req = '0;
        tick(2);
        push_exp(0);
        push_exp(1);
        g0 = grant_log.size();
        bus.req = 3'b011;
        wait_drain(40, "t6_drain");
        check_eq("t6_first", 64'(log_at(g0)), 64'd0);
        check_eq("t6_second", 64'(log_at(g0 + 1)), 64'd1);
        bus.req = '0;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule
`default_nettype wire
